// File: rtl/ray_dispatcher.sv
// ray_dispatcher: FIFO-buffered ray dispatch from one generator to UNITS ray units.
// Optional RAY_DISPATCHER_STATS_EN adds the rayCount/stallCount outputs.
module ray_dispatcher #(
    parameter int POSITION_WIDTH = 16,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int UNITS          = 4,
    parameter int DEPTH          = 4,
    parameter int ROUND_ROBIN    = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        rayStart,
    input  logic [3*POSITION_WIDTH-1:0] rayV,
    input  logic [ADDRESS_WIDTH-1:0]    rayAddress,
    output logic                        rayReady,
    output logic                        rayBusy,
    input  logic                        genBusy,
    output logic [UNITS-1:0]            unitStart,
    output logic [3*POSITION_WIDTH-1:0] unitRayV,
    output logic [ADDRESS_WIDTH-1:0]    unitAddress,
    input  logic [UNITS-1:0]            unitReady,
    input  logic [UNITS-1:0]            unitBusy,
    output logic                        frameDone,
    output logic                        idle
`ifdef RAY_DISPATCHER_STATS_EN
    ,
    output logic [31:0]                 rayCount,
    output logic [31:0]                 stallCount
`endif
);

    localparam int DW = 3 * POSITION_WIDTH + ADDRESS_WIDTH;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = (UNITS > 1) ? $clog2(UNITS) : 1;

    logic [DW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    grant_idx;
    logic [UNITS-1:0] eligible;
    logic [UNITS-1:0] grant;
    logic             found;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             prev_idle;
    logic             frame_q;

    // Index k positions after base, wrapping modulo UNITS.
    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
        return IW'((int'(base) + k) % UNITS);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(DEPTH));
    assign rayReady = !full;
    assign rayBusy  = !empty || (unitBusy != '0);
    assign idle     = !genBusy && empty && (unitBusy == '0) && (unitStart == '0);
    assign frameDone = frame_q;

    // unitStart doubles as lastGrant: it masks the unit that is being started now.
    assign eligible = unitReady & ~unitBusy & ~unitStart;
    assign push     = rayStart && !full && !flush;
    assign pop      = !empty && (eligible != '0) && !flush;

    // Grant select: rotating priority after rr_ptr, or lowest index first.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        if (ROUND_ROBIN != 0) begin
            for (int k = 1; k <= UNITS; k++) begin
                if (!found && eligible[rr_idx(rr_ptr, k)]) begin
                    found     = 1'b1;
                    grant_idx = rr_idx(rr_ptr, k);
                end
            end
        end else begin
            for (int k = 0; k < UNITS; k++) begin
                if (!found && eligible[k]) begin
                    found     = 1'b1;
                    grant_idx = IW'(k);
                end
            end
        end
        grant = found ? (UNITS'(1) << grant_idx) : '0;
    end

    // Ray storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {rayV, rayAddress};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Dispatch register: start pulse, broadcast payload, rotating pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            unitStart   <= '0;
            unitRayV    <= '0;
            unitAddress <= '0;
            rr_ptr      <= IW'(UNITS - 1);
        end else if (flush) begin
            unitStart <= '0;
            rr_ptr    <= IW'(UNITS - 1);
        end else begin
            unitStart <= pop ? grant : '0;
            if (pop) begin
                {unitRayV, unitAddress} <= mem[rd_ptr];
                rr_ptr                  <= grant_idx;
            end
        end
    end

    // Frame completion: registered rising edge of idle; flush re-arms silently.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_idle <= 1'b1;
            frame_q   <= 1'b0;
        end else if (flush) begin
            prev_idle <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            prev_idle <= idle;
            frame_q   <= idle && !prev_idle;
        end
    end

`ifdef RAY_DISPATCHER_STATS_EN
    // Saturating dispatch and full-stall counters, cleared after each frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rayCount   <= '0;
            stallCount <= '0;
        end else if (flush || frame_q) begin
            rayCount   <= '0;
            stallCount <= '0;
        end else begin
            if (pop && rayCount != '1) rayCount <= rayCount + 1'b1;
            if (rayStart && full && stallCount != '1) stallCount <= stallCount + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ray_dispatcher.sv
// tb_ray_dispatcher: directed and random checks of ray_dispatcher against a queue model.
// A second instance in lowest-index mode covers the priority grant.
module tb_ray_dispatcher;

    localparam int PW = 16;
    localparam int AW = 32;
    localparam int U  = 4;
    localparam int D  = 4;
    localparam int DW = 3 * PW + AW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          rayStart = 1'b0;
    logic          genBusy = 1'b0;
    logic [3*PW-1:0] rayV = '0;
    logic [AW-1:0] rayAddress = '0;
    logic [U-1:0]  unitReady = '0;
    logic [U-1:0]  unitBusy = '0;
    logic          rayReady, rayBusy, frameDone, idle;
    logic [U-1:0]  unitStart;
    logic [3*PW-1:0] unitRayV;
    logic [AW-1:0] unitAddress;

    logic          rs_p = 1'b0;
    logic [U-1:0]  ur_p = '0;
    logic [U-1:0]  ub_p = '0;
    logic          p_ready, p_busy, p_fd, p_idle;
    logic [U-1:0]  p_start;
    logic [3*PW-1:0] p_v;
    logic [AW-1:0] p_addr;
`ifdef RAY_DISPATCHER_STATS_EN
    logic [31:0]   rayCount, stallCount, p_rc, p_sc;
`endif

    always #5 clock = ~clock;

    ray_dispatcher #(
        .POSITION_WIDTH(PW), .ADDRESS_WIDTH(AW), .UNITS(U),
        .DEPTH(D), .ROUND_ROBIN(1)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .rayStart(rayStart), .rayV(rayV), .rayAddress(rayAddress),
        .rayReady(rayReady), .rayBusy(rayBusy), .genBusy(genBusy),
        .unitStart(unitStart), .unitRayV(unitRayV),
        .unitAddress(unitAddress), .unitReady(unitReady),
        .unitBusy(unitBusy), .frameDone(frameDone), .idle(idle)
`ifdef RAY_DISPATCHER_STATS_EN
        , .rayCount(rayCount), .stallCount(stallCount)
`endif
    );

    ray_dispatcher #(
        .POSITION_WIDTH(PW), .ADDRESS_WIDTH(AW), .UNITS(U),
        .DEPTH(D), .ROUND_ROBIN(0)
    ) dut_pri (
        .clock(clock), .reset(reset), .flush(flush),
        .rayStart(rs_p), .rayV(rayV), .rayAddress(rayAddress),
        .rayReady(p_ready), .rayBusy(p_busy), .genBusy(genBusy),
        .unitStart(p_start), .unitRayV(p_v),
        .unitAddress(p_addr), .unitReady(ur_p),
        .unitBusy(ub_p), .frameDone(p_fd), .idle(p_idle)
`ifdef RAY_DISPATCHER_STATS_EN
        , .rayCount(p_rc), .stallCount(p_sc)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] mq[$];
    int            m_ptr;
    logic [U-1:0]  m_us;
    logic [3*PW-1:0] m_uv;
    logic [AW-1:0] m_ua;
    logic          m_prev, m_fd;
    logic [31:0]   m_rc, m_sc;
    bit            acc;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ptr  = U - 1;
        m_us   = '0;
        m_uv   = '0;
        m_ua   = '0;
        m_prev = 1'b1;
        m_fd   = 1'b0;
        m_rc   = '0;
        m_sc   = '0;
    endtask

    function automatic logic m_idle();
        return !genBusy && mq.size() == 0 && unitBusy == '0 && m_us == '0;
    endfunction

    task automatic check_all();
        chk("rayReady", DW'(rayReady), DW'(mq.size() < D));
        chk("rayBusy", DW'(rayBusy), DW'(mq.size() != 0 || unitBusy != '0));
        chk("unitStart", DW'(unitStart), DW'(m_us));
        chk("unitRayV", DW'(unitRayV), DW'(m_uv));
        chk("unitAddress", DW'(unitAddress), DW'(m_ua));
        chk("frameDone", DW'(frameDone), DW'(m_fd));
        chk("idle", DW'(idle), DW'(m_idle()));
`ifdef RAY_DISPATCHER_STATS_EN
        chk("rayCount", DW'(rayCount), DW'(m_rc));
        chk("stallCount", DW'(stallCount), DW'(m_sc));
`endif
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rayReady"}, DW'(rayReady), DW'(1));
        chk({tag, "_rayBusy"}, DW'(rayBusy), DW'(0));
        chk({tag, "_unitStart"}, DW'(unitStart), DW'(0));
        chk({tag, "_unitRayV"}, DW'(unitRayV), DW'(0));
        chk({tag, "_unitAddress"}, DW'(unitAddress), DW'(0));
        chk({tag, "_frameDone"}, DW'(frameDone), DW'(0));
        chk({tag, "_idle"}, DW'(idle), DW'(1));
    endtask

    // One clock: advance the model from current inputs, then compare after the edge.
    task automatic tick();
        logic [U-1:0] elig;
        int g;
        bit idl, pop, push;
        idl  = m_idle();
        elig = unitReady & ~unitBusy & ~m_us;
        push = rayStart && mq.size() < D;
        acc  = push && !flush;
        if (flush) begin
            mq.delete();
            m_us   = '0;
            m_ptr  = U - 1;
            m_fd   = 1'b0;
            m_prev = 1'b1;
            m_rc   = '0;
            m_sc   = '0;
        end else begin
            g = -1;
            for (int k = 1; k <= U; k++) begin
                int i;
                i = (m_ptr + k) % U;
                if (g < 0 && ((elig >> i) & 4'd1) != 0) g = i;
            end
            pop = mq.size() != 0 && g >= 0;
            if (m_fd) begin
                m_rc = '0;
                m_sc = '0;
            end else begin
                if (pop && m_rc != '1) m_rc++;
                if (rayStart && mq.size() == D && m_sc != '1) m_sc++;
            end
            m_fd   = idl && !m_prev;
            m_prev = idl;
            if (pop) begin
                {m_uv, m_ua} = mq.pop_front();
                m_us  = 4'd1 << g;
                m_ptr = g;
            end else begin
                m_us = '0;
            end
            if (push) mq.push_back({rayV, rayAddress});
        end
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic rand_ray(input logic [AW-1:0] a);
        rayV       = {16'($urandom()), 32'($urandom())};
        rayAddress = a;
    endtask

    initial begin
        int sent;
        int cyc;
        model_reset();
        #12;
        chk_reset("reset");
        chk("reset_p_start", DW'(p_start), DW'(0));
        @(negedge clock);
        reset     = 1'b0;
        genBusy   = 1'b1;
        unitReady = 4'hF;

        // lowest-index mode: units 1 and 3 ready
        ur_p = 4'b1010;
        rs_p = 1'b1;
        rand_ray(32'h200);
        tick();
        chk("pri_lat", DW'(p_start), DW'(0));
        rand_ray(32'h201);
        tick();
        rs_p = 1'b0;
        chk("pri_first", DW'(p_start), DW'(4'b0010));
        chk("pri_first_addr", DW'(p_addr), DW'(32'h200));
        tick();
        chk("pri_second", DW'(p_start), DW'(4'b1000));
        chk("pri_second_addr", DW'(p_addr), DW'(32'h201));
        tick();
        chk("pri_done", DW'(p_start), DW'(0));

        // basic round robin, first start at N+2
        for (int i = 0; i < 6; i++) begin
            rayStart = (i < 4);
            rand_ray(32'h100 + 32'(i));
            tick();
            if (i >= 1 && i <= 4) begin
                chk("basic_start", DW'(unitStart), DW'(4'd1 << (i - 1)));
                chk("basic_addr", DW'(unitAddress), DW'(32'h100 + 32'(i - 1)));
            end
        end

        // backpressure: fill, stall, then drain to unit 2 only
        unitReady = 4'b0000;
        rayStart  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_ray(32'h300 + 32'(i));
            tick();
        end
        rand_ray(32'h304);
        for (int i = 0; i < 3; i++) tick();
        chk("bp_ready_low", DW'(rayReady), DW'(0));
        unitReady = 4'b0100;
        sent = 4;
        cyc  = 0;
        while (!(sent == 6 && mq.size() == 0 && m_us == '0) && cyc < 60) begin
            tick();
            cyc++;
            if (unitStart != '0) chk("bp_unit2", DW'(unitStart), DW'(4'b0100));
            if (acc) begin
                sent++;
                if (sent < 6) rand_ray(32'h300 + 32'(sent));
                else rayStart = 1'b0;
            end
        end
        chk("bp_drained", DW'(sent == 6 && mq.size() == 0), DW'(1));

        // random traffic with occasional flush
        for (int i = 0; i < 300; i++) begin
            rayStart  = ($urandom_range(0, 1) == 1);
            rand_ray($urandom());
            unitReady = 4'($urandom());
            unitBusy  = 4'($urandom()) & 4'($urandom());
            genBusy   = ($urandom_range(0, 7) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 1'b0;

        // frame done
        rayStart  = 1'b1;
        genBusy   = 1'b1;
        unitReady = 4'hF;
        unitBusy  = 4'b0001;
        rand_ray(32'h400);
        tick();
        rayStart = 1'b0;
        cyc = 0;
        while (!(mq.size() == 0 && m_us == '0) && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("fd_drained", DW'(mq.size() == 0 && m_us == '0), DW'(1));
        genBusy = 1'b0;
        tick();
        chk("fd_not_idle", DW'(idle), DW'(0));
        unitBusy = '0;
        #1;
        chk("fd_idle_rise", DW'(idle), DW'(1));
        chk("fd_no_early", DW'(frameDone), DW'(0));
        tick();
        chk("fd_pulse", DW'(frameDone), DW'(1));
        tick();
        chk("fd_single", DW'(frameDone), DW'(0));
        tick();
        chk("fd_quiet", DW'(frameDone), DW'(0));

        // flush with three entries queued
        unitReady = '0;
        rayStart  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ray(32'h500 + 32'(i));
            tick();
        end
        rayStart = 1'b0;
        chk("fl_queued", DW'(rayBusy), DW'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_busy", DW'(rayBusy), DW'(0));
        chk("fl_start", DW'(unitStart), DW'(0));
        tick();
        chk("fl_no_fd", DW'(frameDone), DW'(0));
        chk("fl_idle", DW'(idle), DW'(1));

        // asynchronous reset mid-dispatch
        genBusy   = 1'b1;
        unitReady = 4'hF;
        rayStart  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ray(32'h600 + 32'(i));
            tick();
        end
        chk("ar_inflight", DW'(unitStart != '0), DW'(1));
        rayStart = 1'b0;
        genBusy  = 1'b0;
        unitBusy = '0;
        #2;
        reset = 1'b1;
        #1;
        chk_reset("areset");
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ray_dispatcher.md
# ray_dispatcher

Multi-unit ray dispatch stage that sits between the ray generator and a bank of `UNITS` ray units. It buffers generated rays in a small FIFO and hands each ray to a free unit using a compile-time arbitration mode. It reports aggregate busy/idle status and a frame-completion pulse. Replacing the single generator-to-unit link with this block lets one tracer scale to several memory masters.

## Interface
Parameters:
- `POSITION_WIDTH`, 16, width of each ray direction component
- `ADDRESS_WIDTH`, 32, pixel address width
- `UNITS`, 4, number of ray units (1..16)
- `DEPTH`, 4, ray FIFO entries (power of 2, ≥2)
- `ROUND_ROBIN`, 1, 1 = rotating-priority grant, 0 = lowest-index-first grant

Ports:
- `clock` in 1: single clock
- `reset` in 1: asynchronous, active-high reset
- `flush` in 1: synchronous clear of FIFO and grant state
- `rayStart` in 1: generator presents a ray; sampled only when `rayReady`=1
- `rayV` in 3×`POSITION_WIDTH`: ray direction {z,y,x}
- `rayAddress` in `ADDRESS_WIDTH`: destination pixel address
- `rayReady` out 1: FIFO not full
- `rayBusy` out 1: FIFO non-empty or any unit busy
- `genBusy` in 1: generator still producing rays for this frame
- `unitStart` out `UNITS`: one-hot start pulse
- `unitRayV` out 3×`POSITION_WIDTH`: broadcast ray direction
- `unitAddress` out `ADDRESS_WIDTH`: broadcast pixel address
- `unitReady` in `UNITS`: unit can accept a ray
- `unitBusy` in `UNITS`: unit is tracing
- `frameDone` out 1: one-cycle completion pulse
- `idle` out 1: level, all work drained

## Operation
- Accept: the FIFO writes {rayV, rayAddress} on a cycle with `rayStart && rayReady`. `rayStart` while full is ignored and the ray is not stored. The generator must hold the ray.
- Dispatch: when the FIFO is non-empty and the eligible set is nonzero, pop one entry, register it onto `unitRayV`/`unitAddress`, and pulse the granted bit of `unitStart` for exactly one cycle.
- Eligible set = `unitReady & ~unitBusy & ~lastGrant`. `lastGrant` masks the unit started in the previous cycle. This covers a unit's one-cycle `unitReady` deassert latency.
- Grant when `ROUND_ROBIN`=1: the first eligible index strictly after the previous grant, wrapping from `UNITS`-1 to 0. The pointer resets to `UNITS`-1, so the first grant goes to unit 0.
- Grant when `ROUND_ROBIN`=0: lowest eligible index.
- At most one dispatch per cycle.
- Simultaneous push and pop is allowed. The occupancy count is unchanged.
- `unitRayV`/`unitAddress` hold their last value when no dispatch occurs.
- `idle` = !`genBusy` && FIFO empty && `unitBusy`==0 && `unitStart`==0.
- `frameDone` pulses on the rising edge of `idle`. It never pulses out of reset.
- `flush`: empty the FIFO, clear `unitStart` and `lastGrant`, and reset the RR pointer. Data arriving on the flush cycle is dropped. `flush` does not generate `frameDone`.
- `reset` mid-operation: all state returns to reset values immediately.

## Timing
- Reset values:
  - `rayReady`=1
  - `rayBusy`=0
  - `unitStart`=0
  - `unitRayV`=0, `unitAddress`=0
  - `frameDone`=0
  - `idle`=1; the internal previous-idle register also resets to 1
- Latency: a ray sampled in cycle N into an empty FIFO with a free unit gives `unitStart` high in cycle N+2.
- Throughput: one ray per cycle, provided successive grants go to different units.
- `rayReady` is combinational from occupancy (full ⇒ 0). It deasserts in the cycle after the write that fills the FIFO.
- `frameDone` is registered. It is high in the cycle after `idle` first becomes true.

## Configuration
- `RAY_DISPATCHER_STATS_EN` defined: adds two output ports.
  - `rayCount` [31:0]: counts dispatches.
  - `stallCount` [31:0]: counts cycles where the FIFO is full and `rayStart`=1.
  - Both clear on `reset`, `flush`, and the `frameDone` cycle+1. They saturate at all-ones.
- `RAY_DISPATCHER_STATS_EN` undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- **Basic:** UNITS=4, RR. Push 4 rays with addresses 0x100..0x103, all units ready. Required: `unitStart` = 0001, 0010, 0100, 1000 on consecutive cycles; `unitAddress` follows 0x100..0x103; first start at cycle N+2.
- **Backpressure:** DEPTH=4, all `unitReady`=0. Push 6 rays. Required: `rayReady` drops after the 4th; rays 5–6 are held by the generator. Then raise `unitReady`[2] alone. Required: rays drain only to unit 2, at most one every 2 cycles.
- **Priority mode:** ROUND_ROBIN=0, units 1 and 3 ready. Push 2 rays. Required: the first goes to unit 1 (0010); the second goes to unit 3, because unit 1 is masked by `lastGrant`.
- **Frame done:** after the last ray, drop `genBusy`, then drop the final `unitBusy`. Required: `idle` rises, and `frameDone` is a single pulse one cycle later; no second pulse while idle persists.
- **Flush and reset:** flush with 3 entries queued. Required: next cycle `rayBusy`=0 (units idle), no `unitStart`, no `frameDone`. Separately, assert async `reset` mid-dispatch. Required: all outputs at reset values before the next edge.
- **Stats** (`RAY_DISPATCHER_STATS_EN`): 10 dispatches plus 3 full-stall cycles. Required: `rayCount`=10 and `stallCount`=3; both read 0 two cycles after `frameDone`.
